// File: rtl/shared_dff_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register with q/qbar outputs.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module shared_dff_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       sclr,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qbar,
    output logic                   busy
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [N_REQ-1:0] ack_reg, ack_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [IW-1:0]    winner_reg, winner_next;
    logic [IW-1:0]    win_idx;
    logic             win_found;
    logic [N_REQ-1:0] win_onehot;
    logic [WIDTH-1:0] wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef ARB_FIXED_PRIO_EN
    // Descending scan so the lowest set index is the last (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [IW:0]   cand;

    // Offsets scanned far-to-near so the nearest requester after the pointer wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, ptr_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end
`endif

    assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        ack_next    = ack_reg;
        q_next      = q_reg;
        winner_next = winner_reg;
`ifndef ARB_FIXED_PRIO_EN
        ptr_next    = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    winner_next = win_idx;
                    gnt_next    = win_onehot;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                if (req[winner_reg]) begin
                    q_next     = sclr[winner_reg] ? '0 : wdata_arr[winner_reg];
                    ack_next   = gnt_reg;
                    state_next = ACK;
                end else begin
                    // Requester withdrew: drop the grant without writing or moving the pointer.
                    gnt_next   = '0;
                    state_next = IDLE;
                end
            end
            ACK: begin
                ack_next   = '0;
                gnt_next   = '0;
                state_next = IDLE;
`ifndef ARB_FIXED_PRIO_EN
                ptr_next   = winner_reg;
`endif
            end
            default: begin
                gnt_next   = '0;
                ack_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            ack_reg    <= '0;
            q_reg      <= '0;
            winner_reg <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_reg    <= IW'(N_REQ - 1);
`endif
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            ack_reg    <= ack_next;
            q_reg      <= q_next;
            winner_reg <= winner_next;
`ifndef ARB_FIXED_PRIO_EN
            ptr_reg    <= ptr_next;
`endif
        end
    end

    assign gnt  = gnt_reg;
    assign ack  = ack_reg;
    assign q    = q_reg;
    assign qbar = ~q_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_shared_dff_arbiter.sv
// Self-checking bench for shared_dff_arbiter: vector table, hand-written corner sequences, random vs model.
module tb_shared_dff_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           clear_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   sclr = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   q, qbar;
    logic           busy;

    int n_pass = 0;
    int n_total = 0;
    int m_ptr = N - 1;
    logic [W-1:0] m_q = '0;

    shared_dff_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .clear_n(clear_n), .req(req), .sclr(sclr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .qbar(qbar), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   req;
        logic [N-1:0]   sclr;
        logic [N*W-1:0] wdata;
        int             exp_w;
        logic [W-1:0]   exp_q;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first requester after the last winner, cyclically.
    function automatic int model_pick(input logic [N-1:0] m);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (m[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic do_reset();
        req = '0; sclr = '0; wdata = '0;
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        m_ptr = N - 1;
        m_q = '0;
    endtask

    task automatic run_txn(input string name, input logic [N-1:0] m, input logic [N-1:0] s,
                           input logic [N*W-1:0] d, input int w, input logic [W-1:0] eq,
                           input bit keep);
        logic [N-1:0] oh;
        logic [W-1:0] nq;
        oh = 4'b0001 << w;
        nq = ~eq;
        req = m; sclr = s; wdata = d;
        step();
        chk({name, " gnt"}, 32'(gnt), 32'(oh));
        chk({name, " busy"}, 32'(busy), 32'd1);
        chk({name, " ack_early"}, 32'(ack), 32'd0);
        step();
        chk({name, " q"}, 32'(q), 32'(eq));
        chk({name, " qbar"}, 32'(qbar), 32'(nq));
        chk({name, " ack"}, 32'(ack), 32'(oh));
        chk({name, " gnt_hold"}, 32'(gnt), 32'(oh));
        step();
        chk({name, " ack_end"}, 32'(ack), 32'd0);
        chk({name, " gnt_end"}, 32'(gnt), 32'd0);
        chk({name, " busy_end"}, 32'(busy), 32'd0);
        if (!keep) req = '0;
        m_ptr = w;
        m_q = eq;
        $display("txn %s req=%b sclr=%b winner=%0d q=%h", name, m, s, w, q);
    endtask

    task automatic do_abort(input string name, input logic [N-1:0] m);
        logic [N-1:0] oh;
        logic [W-1:0] nq;
        oh = 4'b0001 << model_pick(m);
        nq = ~m_q;
        req = m;
        step();
        chk({name, " gnt"}, 32'(gnt), 32'(oh));
        req = '0;
        step();
        chk({name, " gnt_drop"}, 32'(gnt), 32'd0);
        chk({name, " no_ack"}, 32'(ack), 32'd0);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " q_hold"}, 32'(q), 32'(m_q));
        chk({name, " qbar_hold"}, 32'(qbar), 32'(nq));
        $display("txn %s req=%b aborted q=%h", name, m, q);
    endtask

    initial begin
        int fair_w [5];
        int fix_w [4];
        logic [N-1:0]   rm, rs;
        logic [N*W-1:0] rd;
        int             rw;
        logic [W-1:0]   rq;

`ifdef ARB_FIXED_PRIO_EN
        vecs[0] = '{4'b0001, 4'b0000, 32'h000000A5, 0, 8'hA5};
        vecs[1] = '{4'b1111, 4'b0000, 32'h44332211, 0, 8'h11};
        vecs[2] = '{4'b0101, 4'b0000, 32'h003C005A, 0, 8'h5A};
        vecs[3] = '{4'b0100, 4'b0100, 32'h00FF0000, 2, 8'h00};
        vecs[4] = '{4'b1001, 4'b0001, 32'hC3000077, 0, 8'h00};
        vecs[5] = '{4'b1001, 4'b0001, 32'hC3000077, 0, 8'h00};
        fair_w = '{0, 0, 0, 0, 0};
        fix_w  = '{1, 1, 1, 1};
`else
        vecs[0] = '{4'b0001, 4'b0000, 32'h000000A5, 0, 8'hA5};
        vecs[1] = '{4'b1111, 4'b0000, 32'h44332211, 1, 8'h22};
        vecs[2] = '{4'b0101, 4'b0000, 32'h003C005A, 2, 8'h3C};
        vecs[3] = '{4'b0100, 4'b0100, 32'h00FF0000, 2, 8'h00};
        vecs[4] = '{4'b1001, 4'b0001, 32'hC3000077, 3, 8'hC3};
        vecs[5] = '{4'b1001, 4'b0001, 32'hC3000077, 0, 8'h00};
        fair_w = '{0, 1, 2, 3, 0};
        fix_w  = '{1, 3, 1, 3};
`endif

        // Reset state, observed before any clock edge.
        #2 clear_n = 1'b0;
        #1;
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst q", 32'(q), 32'd0);
        chk("rst qbar", 32'(qbar), 32'hFF);
        chk("rst busy", 32'(busy), 32'd0);
        step();
        clear_n = 1'b1;
        step();
        chk("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].sclr, vecs[i].wdata,
                    vecs[i].exp_w, vecs[i].exp_q, 1'b0);
        end

        // Held requests from all four: one grant every three cycles in fair order.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("fair%0d", i), 4'b1111, 4'b0000, 32'h44332211,
                    fair_w[i], 8'(8'h11 * (fair_w[i] + 1)), 1'b1);
        end
        req = '0;
        step();

        // Abort leaves the pointer where it was.
        do_reset();
        run_txn("abort_pre", 4'b0001, 4'b0000, 32'h00000042, 0, 8'h42, 1'b0);
        do_abort("abort", 4'b0010);
`ifdef ARB_FIXED_PRIO_EN
        run_txn("abort_post", 4'b1111, 4'b0000, 32'h44332211, 0, 8'h11, 1'b0);
`else
        run_txn("abort_post", 4'b1111, 4'b0000, 32'h44332211, 1, 8'h22, 1'b0);
`endif

        // Asynchronous reset while ACK is high.
        req = 4'b0001; sclr = '0; wdata = 32'h00000099;
        step();
        step();
        chk("areset ack_before", 32'(ack), 32'd1);
        chk("areset q_before", 32'(q), 32'h99);
        #2 clear_n = 1'b0;
        #1;
        chk("areset ack", 32'(ack), 32'd0);
        chk("areset gnt", 32'(gnt), 32'd0);
        chk("areset q", 32'(q), 32'd0);
        chk("areset qbar", 32'(qbar), 32'hFF);
        chk("areset busy", 32'(busy), 32'd0);
        req = '0;
        step();
        clear_n = 1'b1;
        m_ptr = N - 1;
        m_q = '0;
        run_txn("post_reset", 4'b1111, 4'b0000, 32'h0D0C0B0A, 0, 8'h0A, 1'b0);

        // Two held requesters: alternate under round-robin, requester 1 always under fixed priority.
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("prio%0d", i), 4'b1010, 4'b0000, 32'h77005500,
                    fix_w[i], (fix_w[i] == 1) ? 8'h55 : 8'h77, 1'b1);
        end
        req = '0;
        step();

        // Random transactions and aborts against the reference model.
        for (int i = 0; i < 40; i++) begin
            rm = 4'($urandom_range(1, 15));
            rs = 4'($urandom);
            rd = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                do_abort($sformatf("rnd_abort%0d", i), rm);
            end else begin
                rw = model_pick(rm);
                rq = rs[rw] ? 8'h00 : rd[rw*W +: W];
                run_txn($sformatf("rnd%0d", i), rm, rs, rd, rw, rq, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shared_dff_arbiter.md
Name: shared_dff_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D-flip-flop register with complementary outputs (q/qbar).
- N_REQ requesters compete for write access. Each request either loads data or synchronously clears the register.
- The block grants one requester at a time, performs the write, acknowledges it, and advances the round-robin pointer.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, width of the shared register.

Ports:
- clk  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; must be held until ack or withdrawn.
- sclr  in  N_REQ  per-requester op select: 1 = clear register, 0 = load wdata.
- wdata  in  N_REQ*WIDTH  requester i data occupies bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant, registered.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- q  out  WIDTH  shared register value.
- qbar  out  WIDTH  bitwise complement of q, always consistent with q.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (clear_n low, asynchronous, any state):
  - FSM goes to IDLE; gnt=0, ack=0, q=0, qbar=all ones, busy=0.
  - Round-robin pointer goes to N_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction discards the transaction; no ack is issued.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If any req bit is high, choose the winner: the first set bit searching upward from pointer+1, wrapping modulo N_REQ.
  - Register gnt=onehot(winner), go to GRANT.
  - If no req is high, stay in IDLE.
- GRANT (one cycle, gnt held):
  - If req[winner] is still high at the edge: q <= sclr[winner] ? 0 : wdata slice of winner; qbar <= ~(same value); go to ACK.
  - If req[winner] has dropped: abort. No write, gnt <= 0, pointer unchanged, go to IDLE.
  - req changes from other requesters are ignored.
- ACK (one cycle):
  - ack[winner]=1 and gnt is held.
  - At the edge: ack <= 0, gnt <= 0, pointer <= winner, go to IDLE.
- Latency: req rising before edge E gives gnt after E, q updated at E+1, ack high during cycle E+1..E+2, IDLE after E+2. Back-to-back writes complete one per 3 cycles.
- A requester still holding req in the IDLE cycle after its ack is treated as a new request. It competes normally; round-robin places it last among the current requesters.
- q/qbar change only on the GRANT->ACK edge or on reset; they hold in all other cycles.
- gnt and ack are one-hot or zero at all times; ack is never set without the matching gnt.
- sclr=1 with any wdata gives q=0, qbar=all ones.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: winner selection in IDLE is fixed priority, lowest index wins. The pointer is neither used nor updated. All other timing is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then single write: clear_n low then high; req=0001, sclr=0, wdata[7:0]=0xA5 -> gnt=0001 next cycle, q=0xA5/qbar=0x5A one cycle later, ack=0001 for 1 cycle, busy low afterwards.
- Round-robin fairness: req=1111 held continuously with distinct data -> grant order 0,1,2,3,0. Each grant takes 3 cycles, and q tracks each winner's data in turn.
- Clear op: q=0x3C, then req[2]=1 with sclr[2]=1 and wdata=0xFF -> q=0x00, qbar=0xFF, ack=0100.
- Abort: req[1] raised, then dropped during GRANT -> no ack, q unchanged, gnt=0. Pointer unchanged: with req=1111 next, requester 1 wins first.
- Async reset mid-op: clear_n low during ACK -> ack, gnt and q go 0 and qbar all ones immediately, without waiting for a clock edge. Next request from requester 0 wins first.
- ARB_FIXED_PRIO_EN defined, req=1010 held -> requester 1 is granted on every transaction and requester 3 never while req[1] stays high.
